// File: rtl/systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// systolic_mac_pe
//
// Processing element for a systolic matrix-multiply array. It forwards both
// operands and the valid bit to the east/south neighbours with one cycle of
// latency. It accumulates DEPTH valid products into a single dot product, and
// emits that dot product with a one-cycle result_valid pulse.
//
// Runtime features:
//   - signed_mode selects two's-complement or unsigned operands.
//   - With SATURATE=1 the sum clamps at the ACC_WIDTH limits; otherwise it
//     wraps modulo 2^ACC_WIDTH. Overflow is reported in both cases.
//   - flush emits a partial accumulation early.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   in_valid      operands valid this cycle
//   signed_mode   1 = signed operands, 0 = unsigned (stable per dot product)
//   flush         emit the partial accumulation now
//   operand1_in   row operand
//   operand2_in   column operand
//   operand1_out  operand1_in delayed by one cycle
//   operand2_out  operand2_in delayed by one cycle
//   valid_out     in_valid delayed by one cycle
//   mac_result    last emitted dot product (held between emissions)
//   result_valid  one-cycle pulse when mac_result updates
//   overflow      emitted result saturated or wrapped
// -----------------------------------------------------------------------------
module systolic_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int DEPTH      = 8,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  signed_mode,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] operand1_in,
  input  logic [DATA_WIDTH-1:0] operand2_in,
  output logic [DATA_WIDTH-1:0] operand1_out,
  output logic [DATA_WIDTH-1:0] operand2_out,
  output logic                  valid_out,
  output logic [ACC_WIDTH-1:0]  mac_result,
  output logic                  result_valid,
  output logic                  overflow
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int CNT_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(DEPTH - 1);

  // Mode limits used when clamping.
  localparam logic [ACC_WIDTH-1:0] UNSIGNED_MAX = {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] SIGNED_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SIGNED_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  count;
  logic                  ovf_sticky;

  logic [PROD_WIDTH-1:0] op1_ext;
  logic [PROD_WIDTH-1:0] op2_ext;
  logic [PROD_WIDTH-1:0] product;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_base;
  logic [ACC_WIDTH:0]    sum_full;
  logic                  ovf_now;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  ovf_total;
  logic                  last_beat;
  logic                  emit;

  // Datapath: product, extension, add, overflow detection and clamping.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    op1_ext   = '0;
    op2_ext   = '0;
    product   = '0;
    prod_ext  = '0;
    acc_base  = '0;
    sum_full  = '0;
    ovf_now   = 1'b0;
    sum       = '0;
    ovf_total = 1'b0;
    last_beat = 1'b0;
    emit      = 1'b0;

    // Extending both operands to the product width first gives a product
    // whose low PROD_WIDTH bits are exact in either mode.
    if (signed_mode) begin
      op1_ext = PROD_WIDTH'($signed(operand1_in));
      op2_ext = PROD_WIDTH'($signed(operand2_in));
    end else begin
      op1_ext = PROD_WIDTH'(operand1_in);
      op2_ext = PROD_WIDTH'(operand2_in);
    end
    product = op1_ext * op2_ext;

    if (signed_mode) prod_ext = ACC_WIDTH'($signed(product));
    else             prod_ext = ACC_WIDTH'(product);

    acc_base = (count == '0) ? '0 : acc;
    sum_full = {1'b0, acc_base} + {1'b0, prod_ext};

    if (signed_mode)
      ovf_now = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                (sum_full[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
    else
      ovf_now = sum_full[ACC_WIDTH];

    sum = sum_full[ACC_WIDTH-1:0];
    if (SATURATE) begin
      if (ovf_sticky && count != '0) begin
        // Already clamped in this dot product: hold the limit value.
        sum = acc;
      end else if (ovf_now) begin
        if (!signed_mode)                 sum = UNSIGNED_MAX;
        else if (acc_base[ACC_WIDTH-1])   sum = SIGNED_MIN;
        else                              sum = SIGNED_MAX;
      end
    end

    ovf_total = ovf_now || (ovf_sticky && count != '0);

    last_beat = in_valid && (count == LAST_BEAT);
    // A flush with nothing accumulated and no beat this cycle is ignored.
    emit      = last_beat || (flush && (count != '0 || in_valid));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      operand1_out <= '0;
      operand2_out <= '0;
      valid_out    <= 1'b0;
      acc          <= '0;
      count        <= '0;
      ovf_sticky   <= 1'b0;
      mac_result   <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      operand1_out <= operand1_in;
      operand2_out <= operand2_in;
      valid_out    <= in_valid;
      result_valid <= emit;

      if (emit) begin
        // A flush with no beat this cycle emits the stored partial sum.
        mac_result <= in_valid ? sum : acc;
        overflow   <= in_valid ? ovf_total : ovf_sticky;
        acc        <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
      end else if (in_valid) begin
        acc        <= sum;
        count      <= count + CNT_WIDTH'(1);
        ovf_sticky <= ovf_total;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_mac_pe
//
// Directed bench for systolic_mac_pe. Three instances share one set of
// inputs:
//   dut_a : ACC_WIDTH=20, DEPTH=4, SATURATE=1 (main function, forwarding)
//   dut_s : ACC_WIDTH=16, DEPTH=4, SATURATE=1 (clamping)
//   dut_w : ACC_WIDTH=16, DEPTH=4, SATURATE=0 (wrapping)
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        signed_mode;
  logic        flush;
  logic [7:0]  op1;
  logic [7:0]  op2;

  logic [7:0]  a_op1_out, a_op2_out, s_op1_out, s_op2_out, w_op1_out, w_op2_out;
  logic        a_valid_out, s_valid_out, w_valid_out;
  logic [19:0] a_mac;
  logic [15:0] s_mac, w_mac;
  logic        a_rv, s_rv, w_rv;
  logic        a_ovf, s_ovf, w_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .DEPTH(4), .SATURATE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .flush(flush), .operand1_in(op1), .operand2_in(op2),
    .operand1_out(a_op1_out), .operand2_out(a_op2_out), .valid_out(a_valid_out),
    .mac_result(a_mac), .result_valid(a_rv), .overflow(a_ovf)
  );

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .DEPTH(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .flush(flush), .operand1_in(op1), .operand2_in(op2),
    .operand1_out(s_op1_out), .operand2_out(s_op2_out), .valid_out(s_valid_out),
    .mac_result(s_mac), .result_valid(s_rv), .overflow(s_ovf)
  );

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .DEPTH(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .flush(flush), .operand1_in(op1), .operand2_in(op2),
    .operand1_out(w_op1_out), .operand2_out(w_op2_out), .valid_out(w_valid_out),
    .mac_result(w_mac), .result_valid(w_rv), .overflow(w_ovf)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, then check forwarding and the result pulse of
  // every instance one cycle later (1 time unit after the edge).
  task automatic beat(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic fl, input logic rv_exp);
    in_valid = v;
    op1      = a;
    op2      = b;
    flush    = fl;
    @(posedge clk);
    #1;
    check("fwd_op1",   32'(a_op1_out),   32'(a));
    check("fwd_op2",   32'(a_op2_out),   32'(b));
    check("fwd_valid", 32'(a_valid_out), 32'(v));
    check("pulse_a",   32'(a_rv),        32'(rv_exp));
    check("pulse_s",   32'(s_rv),        32'(rv_exp));
    check("pulse_w",   32'(w_rv),        32'(rv_exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mac"},  32'(a_mac),       32'd0);
    check({tag, "_rv"},   32'(a_rv),        32'd0);
    check({tag, "_ovf"},  32'(a_ovf),       32'd0);
    check({tag, "_op1"},  32'(a_op1_out),   32'd0);
    check({tag, "_op2"},  32'(a_op2_out),   32'd0);
    check({tag, "_vld"},  32'(a_valid_out), 32'd0);
    check({tag, "_smac"}, 32'(s_mac),       32'd0);
    check({tag, "_wmac"}, 32'(w_mac),       32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b1;
    signed_mode = 1'b0;
    flush       = 1'b1;
    op1         = 8'hAA;
    op2         = 8'h55;
    // Reset overrides in_valid and flush.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;

    // Unsigned back-to-back: 12 + 10 + 42 + 9 = 73.
    beat(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
    beat(1'b1, 8'd5, 8'd2, 1'b0, 1'b0);
    beat(1'b1, 8'd7, 8'd6, 1'b0, 1'b0);
    beat(1'b1, 8'd1, 8'd9, 1'b0, 1'b1);
    check("b2b_mac", 32'(a_mac), 32'd73);
    check("b2b_ovf", 32'(a_ovf), 32'd0);
    idle(1);
    check("b2b_hold", 32'(a_mac), 32'd73);

    // Same beats with bubbles of 1-3 cycles.
    beat(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
    idle(1);
    beat(1'b1, 8'd5, 8'd2, 1'b0, 1'b0);
    idle(2);
    beat(1'b1, 8'd7, 8'd6, 1'b0, 1'b0);
    idle(3);
    beat(1'b1, 8'd1, 8'd9, 1'b0, 1'b1);
    check("gap_mac", 32'(a_mac), 32'd73);
    idle(1);

    // Signed: -12 - 10 + 42 + 9 = 29.
    signed_mode = 1'b1;
    beat(1'b1, 8'hFD, 8'h04, 1'b0, 1'b0);
    beat(1'b1, 8'h05, 8'hFE, 1'b0, 1'b0);
    beat(1'b1, 8'd7,  8'd6,  1'b0, 1'b0);
    beat(1'b1, 8'd1,  8'd9,  1'b0, 1'b1);
    check("sgn_mac", 32'(a_mac), 32'h0001D);
    check("sgn_ovf", 32'(a_ovf), 32'd0);
    // (-128)*(-128) = 16384, x4 = 65536.
    repeat (3) beat(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    beat(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    check("sgn_min_mac", 32'(a_mac), 32'd65536);
    check("sgn_min_ovf", 32'(a_ovf), 32'd0);

    // Signed positive overflow: 16129 x4 = 64516.
    repeat (3) beat(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
    beat(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1);
    check("spos_a_mac", 32'(a_mac), 32'd64516);
    check("spos_s_mac", 32'(s_mac), 32'd32767);
    check("spos_s_ovf", 32'(s_ovf), 32'd1);
    check("spos_w_mac", 32'(w_mac), 32'd64516);
    check("spos_w_ovf", 32'(w_ovf), 32'd1);
    // Signed negative overflow: -16256 x4 = -65024.
    repeat (3) beat(1'b1, 8'h80, 8'h7F, 1'b0, 1'b0);
    beat(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
    check("sneg_a_mac", 32'(a_mac), 32'd983552);
    check("sneg_a_ovf", 32'(a_ovf), 32'd0);
    check("sneg_s_mac", 32'(s_mac), 32'h8000);
    check("sneg_s_ovf", 32'(s_ovf), 32'd1);
    check("sneg_w_mac", 32'(w_mac), 32'd512);
    check("sneg_w_ovf", 32'(w_ovf), 32'd1);

    // Unsigned overflow: 65025 x4 = 260100.
    signed_mode = 1'b0;
    repeat (3) beat(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
    beat(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
    check("uovf_a_mac", 32'(a_mac), 32'd260100);
    check("uovf_a_ovf", 32'(a_ovf), 32'd0);
    check("uovf_s_mac", 32'(s_mac), 32'd65535);
    check("uovf_s_ovf", 32'(s_ovf), 32'd1);
    check("uovf_w_mac", 32'(w_mac), 32'd63492);
    check("uovf_w_ovf", 32'(w_ovf), 32'd1);

    // Flush with no beat: 30 + 64 = 94.
    beat(1'b1, 8'd10, 8'd3, 1'b0, 1'b0);
    beat(1'b1, 8'd8,  8'd8, 1'b0, 1'b0);
    beat(1'b0, 8'd0,  8'd0, 1'b1, 1'b1);
    check("flush_mac", 32'(a_mac), 32'd94);
    check("flush_ovf", 32'(a_ovf), 32'd0);
    idle(1);
    repeat (3) beat(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    beat(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    check("post_flush_mac", 32'(a_mac), 32'd4);

    // Flush with nothing accumulated is ignored.
    beat(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    check("flush_empty_mac", 32'(a_mac), 32'd4);

    // Flush on the 4th beat: one emission, 1+1+1+4 = 7.
    repeat (3) beat(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    beat(1'b1, 8'd2, 8'd2, 1'b1, 1'b1);
    check("flush_last_mac", 32'(a_mac), 32'd7);
    idle(1);

    // Flush together with a beat includes that beat: 10 + 9 = 19.
    beat(1'b1, 8'd2, 8'd5, 1'b0, 1'b0);
    beat(1'b1, 8'd3, 8'd3, 1'b1, 1'b1);
    check("flush_beat_mac", 32'(a_mac), 32'd19);

    // Reset mid-accumulation discards the partial sum.
    beat(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
    beat(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    reset = 1'b1;
    repeat (3) beat(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
    beat(1'b1, 8'd2, 8'd3, 1'b0, 1'b1);
    check("post_reset_mac", 32'(a_mac), 32'd24);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
